aes_ctr_stream: RTL
===================

# aes_ctr_stream

CTR-mode streaming front-end that sits directly upstream of the `AES` top and drives its encrypt port (`pt_valid`/`pt_encr`, `ct_rdy`/`ct_encr`). It accepts 128-bit data blocks over a valid/ready stream and sends a counter block for each one to the core. It XORs the returned keystream with the buffered data and presents the result on an output valid/ready stream. It gates all traffic on key-expansion completion (`key_exp_status`) and detects a hung core with a timeout.

## Interface
- `CTR_WIDTH`, 32: width of the incrementing low field of the counter block (1..128).
- `TIMEOUT`, 64: maximum cycles to wait for `aes_done` before flagging an error (≥2).
- `clk`  in  1  clock.
- `reset`  in  1  reset; asynchronous, active-high.
- `cfg_load`  in  1  pulse: load the initial counter block from `cfg_iv`.
- `cfg_iv`  in  128  nonce plus initial counter.
- `key_ready`  in  1  tie to `AES.key_exp_status`.
- `in_valid` / `in_ready`  in / out  1 / 1  input stream handshake.
- `in_data`  in  128  data block (plaintext or ciphertext; CTR is symmetric).
- `in_last`  in  1  final block of the message.
- `out_valid` / `out_ready`  out / in  1 / 1  output stream handshake.
- `out_data`  out  128  `in_data` XOR keystream.
- `out_last`  out  1  copy of the `in_last` of that block.
- `aes_start`  out  1  to `AES.pt_valid`.
- `aes_pt`  out  128  to `AES.pt_encr`; the current counter block.
- `aes_done`  in  1  from `AES.ct_rdy`.
- `aes_ct`  in  128  from `AES.ct_encr`.
- `err`  out  1  sticky timeout flag.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, HOLD. Reset state is IDLE.
- `armed` flag:
  - Set by `cfg_load`.
  - Cleared when a block flagged `in_last` leaves the output, and on timeout.
- `cfg_load` handling:
  - Honoured only in IDLE; ignored in any other state.
  - Loads `ctr <= cfg_iv` and clears `err`.
- `in_ready = (state==IDLE) & armed & key_ready & ~cfg_load`.
- IDLE: on `in_valid & in_ready`, latch `in_data` and `in_last`, then go to ISSUE.
- ISSUE:
  - `aes_start = 1` for exactly this one cycle.
  - Go to WAIT with the timer cleared.
- `aes_pt`: driven with `ctr` in every state, so it is stable around the start pulse.
- WAIT:
  - In the first cycle after ISSUE, `aes_done` is ignored (blanking; the core's ready may still be high from the previous block).
  - From the second WAIT cycle on, `aes_done = 1` triggers:
    - `out_data <= data ^ aes_ct` and `out_last <= last`;
    - increment `ctr[CTR_WIDTH-1:0]` modulo 2^CTR_WIDTH, with `ctr[127:CTR_WIDTH]` unchanged (no carry out);
    - go to HOLD.
  - The timer counts WAIT cycles. If it reaches `TIMEOUT` without a done: set `err`, drop the block, leave `ctr` unchanged, clear `armed`, go to IDLE.
- HOLD:
  - `out_valid = 1`; `out_data` and `out_last` are held stable.
  - On `out_ready`: go to IDLE, and clear `armed` if `out_last`.
- `key_ready` dropping mid-block does not abort the block; it only blocks new acceptances.
- Reset values: `in_ready` 0, `out_valid` 0, `out_data` 0, `out_last` 0, `aes_start` 0, `aes_pt` 0 (`ctr` 0), `err` 0, `busy` 0, `armed` 0.
- Async reset during WAIT or HOLD discards the block. The FSM restarts in IDLE, and `cfg_load` is required again.

## Timing
- Input accepted at edge T: `aes_start` high in cycle T+1; WAIT begins at T+2; `aes_done` is sampled from T+3 onward.
- Done sampled at cycle D: `out_valid` high from D+1.
- Minimum latency from accept to `out_valid` is 4 cycles. There is one block in flight; there is no overlap.
- Back-to-back: the next `in_ready` is asserted the cycle after the `out_valid & out_ready` handshake.
- `out_valid` never drops without a handshake.
- `aes_start` is never high in two consecutive cycles.

## Test plan
- Counter sequence:
  - Stimulus: reset, `key_ready=1`, `cfg_load` with `cfg_iv=0xF0F1…FEFF`, then two blocks.
  - Required: `aes_pt` = `…FCFDFEFF`, then `…FCFDFF00`; `out_data` = NIST SP800-38A F.5.1 ciphertexts (key `2b7e1516…`).
- Wrap:
  - Stimulus: `cfg_iv` low word `0xFFFFFFFF`, two blocks.
  - Required: the second `aes_pt` low word is `0x00000000` and bits [127:32] are unchanged.
- Gating:
  - With `key_ready=0`, or without a prior `cfg_load`: `in_ready` stays 0 for 100 cycles with `in_valid=1`.
  - `cfg_load` asserted in the same cycle as `in_valid`: no accept that cycle.
- Backpressure:
  - Stimulus: `out_ready=0` for 20 cycles in HOLD.
  - Required: `out_data` stable, `in_ready=0`, no `aes_start`.
  - After `out_ready` rises: a single transfer, and `in_ready` rises the next cycle.
- Stale done:
  - Stimulus: `aes_done` held at 1 continuously.
  - Required: each result is captured no earlier than 2 cycles after `aes_start`, and `out_data` equals `data ^ aes_ct` sampled in that cycle.
- Timeout and reset:
  - Stimulus: `aes_done=0` forever with `TIMEOUT=64`.
  - Required: `err=1` exactly 64 WAIT cycles after entry, FSM in IDLE, `in_ready=0`.
  - Follow-up: `cfg_load` clears `err`.
  - Separately: `reset` asserted mid-WAIT drives all outputs to 0 immediately.

Source files
------------

// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream
// CTR-mode streaming front-end for an AES encrypt core. Each 128-bit data
// block accepted on the input stream causes one counter block to be issued to
// the core. The returned keystream is XORed with the buffered block and the
// result is presented on the output stream. Only one block is in flight at a
// time. Traffic is gated on key expansion and on a prior counter load, and a
// core that never answers is detected with a timeout.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   cfg_load, cfg_iv      load pulse and initial counter block (nonce + counter)
//   key_ready             key expansion complete (AES.key_exp_status)
//   in_valid/in_ready     input stream handshake; in_data, in_last payload
//   out_valid/out_ready   output stream handshake; out_data, out_last payload
//   aes_start, aes_pt     start pulse and counter block to the core
//   aes_done, aes_ct      core ready and keystream from the core
//   err                   sticky timeout flag, cleared by cfg_load
//   busy                  high whenever a block is in flight
module aes_ctr_stream #(
    parameter int CTR_WIDTH = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_load,
    input  logic [127:0] cfg_iv,
    input  logic         key_ready,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last,
    output logic         aes_start,
    output logic [127:0] aes_pt,
    input  logic         aes_done,
    input  logic [127:0] aes_ct,
    output logic         err,
    output logic         busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t        state_q, state_d;
    logic [127:0]  ctr_q, ctr_d;
    logic [127:0]  data_q, data_d;
    logic [127:0]  out_data_q, out_data_d;
    logic          last_q, last_d;
    logic          out_last_q, out_last_d;
    logic          armed_q, armed_d;
    logic          err_q, err_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          accept;
    logic          done_seen;
    logic          timed_out;

    assign accept    = in_valid & in_ready;
    // The first WAIT cycle (timer still zero) is blanked: the core's ready
    // may still be asserted from the previous block.
    assign done_seen = (timer_q != '0) & aes_done;
    // Last WAIT cycle before giving up on the core.
    assign timed_out = ~done_seen & (timer_q == TW'(TIMEOUT - 1));

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ctr_q      <= '0;
            data_q     <= '0;
            out_data_q <= '0;
            last_q     <= 1'b0;
            out_last_q <= 1'b0;
            armed_q    <= 1'b0;
            err_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            data_q     <= data_d;
            out_data_q <= out_data_d;
            last_q     <= last_d;
            out_last_q <= out_last_d;
            armed_q    <= armed_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (done_seen)      state_d = HOLD;
                else if (timed_out) state_d = IDLE;
            end
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        ctr_d      = ctr_q;
        data_d     = data_q;
        last_d     = last_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        armed_d    = armed_q;
        err_d      = err_q;
        timer_d    = timer_q;
        case (state_q)
            IDLE: begin
                // cfg_load masks in_ready, so load and accept never coincide.
                if (cfg_load) begin
                    ctr_d   = cfg_iv;
                    err_d   = 1'b0;
                    armed_d = 1'b1;
                end
                if (accept) begin
                    data_d = in_data;
                    last_d = in_last;
                end
            end
            ISSUE: timer_d = '0;
            WAIT: begin
                if (done_seen) begin
                    out_data_d = data_q ^ aes_ct;
                    out_last_d = last_q;
                    // Only the low field counts; the nonce above it never
                    // receives a carry.
                    ctr_d[CTR_WIDTH-1:0] = ctr_q[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    armed_d = 1'b0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HOLD: begin
                if (out_ready && out_last_q) armed_d = 1'b0;
            end
            default: ;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready  = (state_q == IDLE) & armed_q & key_ready & ~cfg_load;
        out_valid = (state_q == HOLD);
        aes_start = (state_q == ISSUE);
        busy      = (state_q != IDLE);
    end

    assign out_data = out_data_q;
    assign out_last = out_last_q;
    assign aes_pt   = ctr_q;
    assign err      = err_q;

endmodule
